strobe_capture_sync: RTL



---
 rtl/strobe_capture_sync_if.sv | 27 ++
 rtl/strobe_capture_sync.sv | 101 ++++++++++
 2 files changed

// File: rtl/strobe_capture_sync_if.sv
// Bundles the strobe, data and consumer-handshake signals of strobe_capture_sync.
// master: sender/consumer side (drives strobes, data, rd, overrun_clr).
// slave : the capture block itself (drives captured data and status).
interface strobe_capture_sync_if #(
    parameter int N  = 8,
    parameter int CH = 2
);
    logic [CH-1:0]   stb_in;
    logic [CH*N-1:0] data_in;
    logic [CH-1:0]   rd;
    logic [CH-1:0]   overrun_clr;
    logic [CH*N-1:0] data_out;
    logic [CH-1:0]   valid;
    logic [CH-1:0]   pending;
    logic [CH-1:0]   overrun;
    logic [CH-1:0]   ack;

    modport master (
        output stb_in, data_in, rd, overrun_clr,
        input  data_out, valid, pending, overrun, ack
    );

    modport slave (
        input  stb_in, data_in, rd, overrun_clr,
        output data_out, valid, pending, overrun, ack
    );
endinterface

// File: rtl/strobe_capture_sync.sv
// Purpose: per-channel strobe resynchronizer that captures a quasi-static data bus on a strobe edge.
// Latency: STAGES+1 clk edges from a settled strobe transition to data_out/valid/ack update.
// Backpressure: none; consumer sees pending, unread data overwritten by a new capture raises sticky overrun.
//
// Ports:
//   clk, rst   - single clock, synchronous active-high reset (wins over ena)
//   ena        - global enable; when low every flop holds, synchronizer chain included
//   bus.stb_in - asynchronous strobes, one per channel
//   bus.data_in/data_out - CH channels of N bits, channel c at [c*N +: N]
//   bus.rd / bus.overrun_clr - consumer clears for pending / overrun
//   bus.valid  - one-cycle capture pulse; bus.ack toggles once per capture
module strobe_capture_sync #(
    parameter int N      = 8,
    parameter int CH     = 2,
    parameter int STAGES = 2,
    parameter int TOGGLE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    strobe_capture_sync_if.slave bus
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("strobe_capture_sync: STAGES must be at least 2");
        end
    endgenerate

    // sync_q[c][0] is the first flop after the async input, [STAGES-1] the settled one.
    logic [STAGES-1:0] sync_q [CH];
    logic [CH-1:0]     prev_q;
    logic [CH-1:0]     det;

    logic [CH*N-1:0]   data_q;
    logic [CH-1:0]     valid_q;
    logic [CH-1:0]     pending_q;
    logic [CH-1:0]     overrun_q;
    logic [CH-1:0]     ack_q;

    // Edge detect between the settled sample and the one before it.
    // Pulse mode reacts to rising edges only; toggle mode to either edge.
    always_comb begin
        det = '0;
        for (int c = 0; c < CH; c++) begin
            if (TOGGLE != 0) begin
                det[c] = sync_q[c][STAGES-1] ^ prev_q[c];
            end else begin
                det[c] = sync_q[c][STAGES-1] & ~prev_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                sync_q[c] <= '0;
            end
            prev_q    <= '0;
            data_q    <= '0;
            valid_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            ack_q     <= '0;
        end else if (ena) begin
            for (int c = 0; c < CH; c++) begin
                sync_q[c] <= {sync_q[c][STAGES-2:0], bus.stb_in[c]};
                prev_q[c] <= sync_q[c][STAGES-1];

                valid_q[c] <= det[c];
                if (det[c]) begin
                    data_q[c*N +: N] <= bus.data_in[c*N +: N];
                    ack_q[c]         <= ~ack_q[c];
                end

                // A capture always leaves data pending, even if rd arrives on the same edge:
                // the consumer read the old word, the new one is still unread.
                if (det[c]) begin
                    pending_q[c] <= 1'b1;
                end else if (bus.rd[c]) begin
                    pending_q[c] <= 1'b0;
                end

                // Overrun only when unread data is overwritten; a same-cycle read counts as consumed.
                // Setting has priority over the clear request.
                if (det[c] && pending_q[c] && !bus.rd[c]) begin
                    overrun_q[c] <= 1'b1;
                end else if (bus.overrun_clr[c]) begin
                    overrun_q[c] <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;
    assign bus.ack      = ack_q;

endmodule
